logic_pipe: RTL and testbench

LOGIC_PIPE -- requirements
Module: logic_pipe

---
 rtl/logic_pkg.sv | 26 ++
 rtl/logic_stage.sv | 44 ++++
 rtl/logic_pipe.sv | 92 +++++++++
 tb/tb_logic_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared types and the per-bit operation evaluator for the logic pipeline.
package logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  localparam int unsigned CountWidth = 16;

  // Evaluated one bit at a time so any operand width reuses the same function.
  function automatic logic eval_bit(op_e op, logic x, logic y);
    logic r;
    r = 1'b0;
    unique case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_stage.sv
// One pipeline slice: data word, zero flag and valid bit with elastic advance.
module logic_stage
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             up_zero_i,
  input  logic             dn_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             load;

  // Accept when empty, or when the current word leaves in the same cycle.
  assign load = up_valid_i & (~valid_q | dn_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= up_data_i;
      zero_q  <= up_zero_i;
    end else if (dn_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/logic_pipe.sv
// Elastic bitwise-logic pipeline: AND/OR/XOR/NAND over STAGES register slices.
module logic_pipe
  import logic_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [1:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  zero,
  output logic [CountWidth-1:0] done_count
);

  logic [WIDTH-1:0]      res;
  logic                  res_zero;
  logic [STAGES-1:0]     vld;
  logic [STAGES-1:0]     zro;
  logic [STAGES-1:0]     dn_rdy;
  logic [WIDTH-1:0]      dat [STAGES];
  logic [CountWidth-1:0] done_q;

  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = eval_bit(op_e'(op), a[i], b[i]);
    end
  end

  assign res_zero = ~|res;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic             up_zero;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = res;
      assign up_zero  = res_zero;
    end else begin : g_body
      assign up_valid = vld[k-1];
      assign up_data  = dat[k-1];
      assign up_zero  = zro[k-1];
    end

    // Downstream can take a word if any later slot is free or the sink drains;
    // derived from the valid bits directly so the ready path has no loop.
    if (k == STAGES - 1) begin : g_tail
      assign dn_rdy[k] = out_ready;
    end else begin : g_inner
      assign dn_rdy[k] = out_ready | ~(&vld[STAGES-1:k+1]);
    end

    logic_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .up_valid_i(up_valid),
      .up_data_i (up_data),
      .up_zero_i (up_zero),
      .dn_ready_i(dn_rdy[k]),
      .valid_o   (vld[k]),
      .data_o    (dat[k]),
      .zero_o    (zro[k])
    );
  end

  assign in_ready  = rst_n & (~vld[0] | dn_rdy[0]);
  assign out_valid = vld[STAGES-1];
  assign out       = dat[STAGES-1];
  assign zero      = zro[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
    end else if (out_valid && out_ready) begin
      done_q <= done_q + 1'b1;
    end
  end

  assign done_count = done_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: directed corner cases plus randomized traffic.
module tb_logic_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [15:0] a, b, out, done_count;
  logic [1:0]  op;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero;
  logic [0:0]  s_a, s_b, s_out;
  logic [1:0]  s_op;
  logic [15:0] s_done;

  logic_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op(op), .out_valid(out_valid), .out_ready(out_ready), .out(out), .zero(zero),
    .done_count(done_count)
  );

  logic_pipe #(.WIDTH(1), .STAGES(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a),
    .b(s_b), .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready), .out(s_out),
    .zero(s_zero), .done_count(s_done)
  );

  typedef struct {
    logic [15:0] data;
    logic        zero;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        sq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int unsigned ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic [1:0] iop, input logic ordy, input bit lat, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    out_ready = ordy;
    #2;
    acc = iv && in_ready;
    if (acc) begin
      e.data    = model(iop, ia, ib);
      e.zero    = (e.data == 16'h0);
      e.cyc     = cyc;
      e.chk_lat = lat;
      sbq.push_back(e);
    end
  endtask

  task automatic step_s(input logic iv, input logic ia, input logic ib, output bit acc);
    exp_t e;
    @(negedge clk);
    s_in_valid = iv;
    s_a        = ia;
    s_b        = ib;
    #2;
    acc = iv && s_in_ready;
    if (acc) begin
      e.data    = {15'h0, ia & ib};
      e.zero    = !(ia & ib);
      e.cyc     = cyc;
      e.chk_lat = 1'b1;
      sq.push_back(e);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 40 && sbq.size() != 0; i++) step(1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b0, acc);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 beats outstanding", sbq.size());
    end
  endtask

  // Main-DUT monitor: output order/content, latency, hold stability, done_count.
  exp_t        me;
  logic [15:0] held;
  logic        held_zero;
  bit          holding = 1'b0;
  initial forever begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding && out_valid) begin
        check("hold_out", out, held);
        check("hold_zero", zero, held_zero);
      end
      holding   = out_valid && !out_ready;
      held      = out;
      held_zero = zero;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0h expected=no beat", out);
        end else begin
          me = sbq.pop_front();
          check("out", out, me.data);
          check("zero", zero, me.zero);
          if (me.chk_lat) check("latency", cyc - me.cyc, 2);
          check("done_count", done_count, ndone[15:0]);
          ndone++;
        end
      end
    end
  end

  exp_t se;
  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n && s_out_valid && s_out_ready) begin
      if (sq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s_unexpected_out actual=%0h expected=no beat", s_out);
      end else begin
        se = sq.pop_front();
        check("s_out", s_out, se.data);
        check("s_zero", s_zero, se.zero);
        check("s_latency", cyc - se.cyc, 1);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  bit          acc;
  int          accepted;
  logic [15:0] x, y, first_exp;
  logic [1:0]  o;
  logic [1:0]  tt;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_op = 2'b00; s_out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_zero", zero, 0);
    check("rst_out", out, 0);
    check("rst_done", done_count, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("in_ready_after_rst", in_ready, 1);

    // 1-bit, 1-stage AND truth table
    for (int i = 0; i < 4; i++) begin
      tt = 2'(i);
      step_s(1'b1, tt[1], tt[0], acc);
      check("s_accept", acc, 1);
    end
    for (int i = 0; i < 3; i++) step_s(1'b0, 1'b0, 1'b0, acc);
    check("s_queue_empty", sq.size(), 0);

    // Back-to-back ops on fixed operands
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 16'hF0F0, 16'h0FF0, 2'(i), 1'b1, 1'b1, acc);
      check("b2b_accept", acc, 1);
    end
    drain();

    // Backpressure: fill, stall, then simultaneous in/out transfer
    x = 16'($urandom); y = 16'($urandom); o = 2'($urandom);
    first_exp = model(o, x, y);
    step(1'b1, x, y, o, 1'b0, 1'b0, acc);
    check("bp_accept1", acc, 1);
    step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'b0, 1'b0, acc);
    check("bp_accept2", acc, 1);
    x = 16'($urandom); y = 16'($urandom); o = 2'($urandom);
    step(1'b1, x, y, o, 1'b0, 1'b0, acc);
    check("bp_reject3", acc, 0);
    step(1'b1, x, y, o, 1'b0, 1'b0, acc);
    check("bp_reject3_again", acc, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_held", out, first_exp);
    step(1'b1, x, y, o, 1'b1, 1'b0, acc);
    check("bp_accept3_with_out", acc, 1);
    drain();

    // Asynchronous reset with two beats in flight
    step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'b0, 1'b0, acc);
    step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'b0, 1'b0, acc);
    check("pre_rst_done_nonzero", done_count != 16'h0, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_done", done_count, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_zero", zero, 0);
    check("mid_rst_in_ready", in_ready, 0);
    sbq.delete();
    ndone = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b0, acc);
      check("no_stale", out_valid, 0);
    end

    // Randomized handshakes, 1000 beats
    accepted = 0;
    for (int it = 0; it < 20000 && accepted < 1000; it++) begin
      step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 2'($urandom),
           ($urandom % 3) != 0, 1'b0, acc);
      if (acc) accepted++;
    end
    check("random_accepted", accepted, 1000);
    drain();
    check("done_count_1000", done_count, 1000);

    // Counter wrap after 65536 transfers
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    ndone = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom), 1'b1, 1'b1, acc);
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL wrap_accept actual=0 expected=1 beat=%0d", i);
      end
    end
    drain();
    check("done_count_wrap", done_count, 16'h0000);
    check("wrap_transfers", ndone, 65536);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
